// File: rtl/lsu_ctrl_if.sv
// Request/response channel between the execute stage and the load/store controller.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: word-aligned DMem accesses, read-modify-write for sub-word
// stores, sign/zero extension for sub-word loads, misaligned requests rejected.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  lsu_ctrl_if.slave   bus,
  output logic        dmem_we,
  output logic        dmem_re,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_CAP = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        we_r;
  logic [1:0]  size_r;
  logic        uns_r;
  logic        err_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] word_r;
  logic        accept_s;
  logic        misalign_s;

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: r[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign accept_s  = bus.req_valid & (state_r == IDLE);
  assign dmem_addr = {addr_r[31:2], 2'b00};

  // Alignment and size legality of the request currently on the bus
  always_comb begin
    misalign_s = 1'b1;
    case (bus.req_size)
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = bus.req_addr[0];
      2'b10:   misalign_s = |bus.req_addr[1:0];
      default: misalign_s = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Request capture and read-data capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      uns_r   <= 1'b0;
      err_r   <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      word_r  <= 32'd0;
    end else begin
      if (accept_s) begin
        we_r    <= bus.req_we;
        size_r  <= bus.req_size;
        uns_r   <= bus.req_unsigned;
        err_r   <= misalign_s;
        addr_r  <= bus.req_addr;
        wdata_r <= bus.req_wdata;
      end
      if (state_r == RD_CAP) word_r <= dmem_rdata;
    end
  end

  // Next-state logic; a full-word store needs no read phase
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s)                                   state_next_s = IDLE;
        else if (misalign_s)                             state_next_s = RESP;
        else if (bus.req_we && (bus.req_size == 2'b10))  state_next_s = WR;
        else                                             state_next_s = RD_REQ;
      end
      RD_REQ: state_next_s = RD_CAP;
      RD_CAP: begin
        if (we_r) state_next_s = WR;
        else      state_next_s = RESP;
      end
      WR:      state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode; reset forces every strobe low in the same cycle
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'd0;
    bus.resp_err   = 1'b0;
    dmem_we        = 1'b0;
    dmem_re        = 1'b0;
    dmem_wdata     = 32'd0;
    if (rst) begin
      bus.req_ready = 1'b0;
    end else begin
      case (state_r)
        IDLE:   bus.req_ready = 1'b1;
        RD_REQ: dmem_re = 1'b1;
        RD_CAP: dmem_re = 1'b1;
        WR: begin
          dmem_we    = 1'b1;
          dmem_wdata = store_merge(word_r, wdata_r, size_r, addr_r[1:0]);
        end
        RESP: begin
          bus.resp_valid = 1'b1;
          bus.resp_err   = err_r;
          bus.resp_rdata = (err_r | we_r) ? 32'd0
                                          : load_extract(word_r, size_r, uns_r, addr_r[1:0]);
        end
        default: bus.req_ready = 1'b0;
      endcase
    end
  end

endmodule
